// File: rtl/edge_event_scheduler.sv
// Round-robin scheduler that serialises per-requester event pulses into spaced edge pulses.
// Optional build macro EDGE_SCHED_PRIO0_EN gives requester 0 strict priority over the rest.
module edge_event_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 3,
  parameter int GAP_CYCLES = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         event_i,
  input  logic                       enable_i,
  input  logic                       clear_ovf_i,
  output logic                       edge_o,
  output logic [$clog2(NUM_REQ)-1:0] edge_id_o,
  output logic                       busy_o,
  output logic [NUM_REQ-1:0]         pending_o,
  output logic [NUM_REQ-1:0]         overflow_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, FIRE, GAP} state_e;

  state_e               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt [NUM_REQ];
  logic [IDW-1:0]       ptr, edge_id, winner, idx;
  logic [7:0]           gap_cnt;
  logic [NUM_REQ-1:0]   pending, rr_req, ovf, ovf_set;
  logic                 found, take;
  int                   sum;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_REQ; i++) pending[i] = |cnt[i];
  end

  // Winner search starts at ptr and wraps; the winner is latched on the IDLE->FIRE step.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    rr_req = pending;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    sum    = 0;
`ifdef EDGE_SCHED_PRIO0_EN
    rr_req[0] = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IDW'(sum);
      if (!found && rr_req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
`ifdef EDGE_SCHED_PRIO0_EN
    if (pending[0]) winner = '0;
`endif
  end

  assign take = (state == IDLE) && enable_i && (|pending);

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = FIRE;
      FIRE:    state_nxt = GAP;
      GAP:     if (gap_cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    edge_o = (state == FIRE);
    busy_o = (state != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gap_cnt <= '0;
      edge_id <= '0;
      ptr     <= '0;
    end else begin
      if (edge_o)                            gap_cnt <= 8'(GAP_CYCLES - 1);
      else if (state == GAP && gap_cnt != 0) gap_cnt <= gap_cnt - 8'd1;
      if (take) edge_id <= winner;
      if (edge_o) ptr <= (edge_id == IDW'(NUM_REQ - 1)) ? '0 : edge_id + 1'b1;
    end
  end

  // An event into a full counter is dropped unless the same cycle also grants it.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ovf_set[i] = event_i[i] && !(edge_o && edge_id == IDW'(i)) && (cnt[i] == CNT_MAX);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the counter array is state the FSM depends on, so it is reset element by element.
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (event_i[i] && !(edge_o && edge_id == IDW'(i))) begin
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
        end else if (!event_i[i] && edge_o && edge_id == IDW'(i)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
      ovf <= (ovf & ~{NUM_REQ{clear_ovf_i}}) | ovf_set;
    end
  end

  assign edge_id_o  = edge_id;
  assign pending_o  = pending;
  assign overflow_o = ovf;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Bench for edge_event_scheduler: directed scenarios plus random traffic against a counter-level reference model.
module tb_edge_event_scheduler;

  localparam int N    = 4;
  localparam int CW   = 3;
  localparam int GAP  = 6;
  localparam int CMAX = 7;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] event_i;
  logic         enable_i;
  logic         clear_ovf_i;
  logic         edge_o;
  logic [1:0]   edge_id_o;
  logic         busy_o;
  logic [N-1:0] pending_o;
  logic [N-1:0] overflow_o;

  always #5 clk_i = ~clk_i;

  edge_event_scheduler #(.NUM_REQ(N), .CNT_WIDTH(CW), .GAP_CYCLES(GAP)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .event_i    (event_i),
    .enable_i   (enable_i),
    .clear_ovf_i(clear_ovf_i),
    .edge_o     (edge_o),
    .edge_id_o  (edge_id_o),
    .busy_o     (busy_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending counts, busy countdown (GAP+1 means the edge cycle), pointer, last id.
  int           m_cnt [N];
  int           m_ptr, m_busy, m_id;
  logic [N-1:0] m_ovf;

  function automatic int m_pick();
`ifdef EDGE_SCHED_PRIO0_EN
    if (m_cnt[0] > 0) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
`ifdef EDGE_SCHED_PRIO0_EN
      if (j == 0) continue;
`endif
      if (m_cnt[j] > 0) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr  = 0;
    m_busy = 0;
    m_id   = 0;
    m_ovf  = '0;
  endtask

  task automatic model_step(input logic [N-1:0] ev, input logic en, input logic clr);
    bit           fire_now, take, any;
    int           w;
    logic [N-1:0] set;
    fire_now = (m_busy == GAP + 1);
    any = 1'b0;
    for (int i = 0; i < N; i++) if (m_cnt[i] > 0) any = 1'b1;
    take = (m_busy == 0) && en && any;
    w = take ? m_pick() : 0;
    set = '0;
    for (int i = 0; i < N; i++) begin
      bit dec;
      dec = fire_now && (m_id == i);
      if (ev[i] && !dec) begin
        if (m_cnt[i] == CMAX) set[i] = 1'b1;
        else m_cnt[i]++;
      end else if (dec && !ev[i]) begin
        m_cnt[i]--;
      end
    end
    m_ovf = (m_ovf & ~{N{clr}}) | set;
    if (fire_now) m_ptr = (m_id + 1) % N;
    if (m_busy > 0) m_busy--;
    else if (take) begin
      m_busy = GAP + 1;
      m_id   = w;
    end
  endtask

  task automatic compare_outputs();
    logic [N-1:0] exp_pend;
    for (int i = 0; i < N; i++) exp_pend[i] = (m_cnt[i] > 0);
    check("edge",     32'(edge_o),     32'(m_busy == GAP + 1));
    check("edge_id",  32'(edge_id_o),  32'(m_id));
    check("busy",     32'(busy_o),     32'(m_busy > 0));
    check("pending",  32'(pending_o),  32'(exp_pend));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
  endtask

  int cyc;
  int e_cyc[$];
  int e_id[$];
  int busy_first, busy_last, busy_n;

  task automatic clear_log();
    e_cyc.delete();
    e_id.delete();
    busy_first = -1;
    busy_last  = -1;
    busy_n     = 0;
  endtask

  // Called at a falling edge: check this cycle's outputs, drive this cycle's inputs, advance.
  task automatic step(input logic [N-1:0] ev, input logic en, input logic clr);
    compare_outputs();
    if (edge_o) begin
      e_cyc.push_back(cyc);
      e_id.push_back(int'(edge_id_o));
    end
    if (busy_o) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
      busy_n++;
    end
    event_i     = ev;
    enable_i    = en;
    clear_ovf_i = clr;
    @(posedge clk_i);
    model_step(ev, en, clr);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    event_i     = '0;
    enable_i    = 1'b0;
    clear_ovf_i = 1'b0;
    #1;
    check("rst_edge",     32'(edge_o),     32'd0);
    check("rst_edge_id",  32'(edge_id_o),  32'd0);
    check("rst_busy",     32'(busy_o),     32'd0);
    check("rst_pending",  32'(pending_o),  32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc   = 0;
    clear_log();
  endtask

  initial begin
    int exp_ord[4];
    rst_i       = 1'b1;
    event_i     = '0;
    enable_i    = 1'b0;
    clear_ovf_i = 1'b0;
    cyc         = 0;
    clear_log();
    @(negedge clk_i);
    do_reset();

    // Single event on requester 0 in cycle 3.
    repeat (3) step(4'b0000, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    repeat (12) step(4'b0000, 1'b1, 1'b0);
    check("lat_count", 32'(e_cyc.size()), 32'd1);
    if (e_cyc.size() >= 1) begin
      check("lat_cycle", 32'(e_cyc[0]), 32'd5);
      check("lat_id",    32'(e_id[0]),  32'd0);
    end
    check("busy_first", 32'(busy_first), 32'd5);
    check("busy_last",  32'(busy_last),  32'd11);
    check("busy_len",   32'(busy_n),     32'd7);

    // All four requesters at once.
    do_reset();
    step(4'b1111, 1'b1, 1'b0);
    repeat (40) step(4'b0000, 1'b1, 1'b0);
    check("all4_count", 32'(e_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < e_cyc.size(); i++) begin
      check("all4_id", 32'(e_id[i]), 32'(i));
      if (i > 0) check("all4_space", 32'(e_cyc[i] - e_cyc[i-1]), 32'd8);
    end

    // Saturation and overflow on requester 2 while disabled.
    do_reset();
    repeat (9) step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check("sat_ovf",  32'(overflow_o), 32'b0100);
    check("sat_pend", 32'(pending_o),  32'b0100);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    check("sat_clear", 32'(overflow_o), 32'b0000);
    clear_log();
    repeat (70) step(4'b0000, 1'b1, 1'b0);
    check("sat_pulses", 32'(e_cyc.size()), 32'd7);
    foreach (e_id[i]) check("sat_id", 32'(e_id[i]), 32'd2);
    check("sat_drained", 32'(pending_o), 32'd0);

    // Event and grant for requester 1 in the same cycle at count 3.
    do_reset();
    repeat (3) step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    check("same_fire", 32'(edge_o), 32'd1);
    step(4'b0010, 1'b1, 1'b0);
    repeat (50) step(4'b0000, 1'b1, 1'b0);
    check("same_pulses", 32'(e_cyc.size()), 32'd4);
    check("same_ovf",    32'(overflow_o),    32'd0);

    // Reset during GAP with requester 3 still pending.
    do_reset();
    repeat (3) step(4'b1000, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 1'b1, 1'b0);
    check("gap_busy", 32'(busy_o),    32'd1);
    check("gap_pend", 32'(pending_o), 32'b1000);
    do_reset();
    repeat (30) step(4'b0000, 1'b1, 1'b0);
    check("post_rst_edges", 32'(e_cyc.size()), 32'd0);

    // Requesters 0 and 1 each pending two.
    do_reset();
    repeat (2) step(4'b0011, 1'b0, 1'b0);
    repeat (40) step(4'b0000, 1'b1, 1'b0);
`ifdef EDGE_SCHED_PRIO0_EN
    exp_ord = '{0, 0, 1, 1};
`else
    exp_ord = '{0, 1, 0, 1};
`endif
    check("order_count", 32'(e_id.size()), 32'd4);
    for (int i = 0; i < 4 && i < e_id.size(); i++) check("order_id", 32'(e_id[i]), 32'(exp_ord[i]));

    // Random traffic, with one reset part way through.
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      logic [N-1:0] ev;
      if (i == 600) do_reset();
      for (int b = 0; b < N; b++) ev[b] = ($urandom_range(0, 5) == 0);
      step(ev, $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
